// File: rtl/lsu_bus_master.sv
// rtl/lsu_bus_master.sv - load/store unit bus master for a byte-lane BRAM array port
// Optional feature: define LSU_MISALIGN_CHECK_EN to reject misaligned halfword/word accesses.
module lsu_bus_master #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [1:0]  i_req_size,
  input  logic        i_req_unsigned,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err,
  output logic        o_en,
  output logic        o_we,
  output logic [1:0]  o_mask_type,
  output logic [31:0] o_addr,
  output logic [31:0] o_data,
  input  logic [31:0] i_data,
  input  logic        i_ack,
  input  logic        i_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic        we_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [7:0]  cnt_q;

  logic        misalign;
  logic        reject;
  logic        accept;
  logic        timeout_hit;
  logic [31:0] load_ext;

`ifdef LSU_MISALIGN_CHECK_EN
  // Flag halfwords on odd addresses and words off a 4-byte boundary.
  always_comb begin
    misalign = 1'b0;
    case (i_req_size)
      2'b01:   misalign = i_req_addr[0];
      2'b10:   misalign = |i_req_addr[1:0];
      default: misalign = 1'b0;
    endcase
  end
`else
  // Misaligned accesses go to the memory as-is; its lane logic decides.
  assign misalign = 1'b0;
`endif

  assign reject      = (i_req_size == 2'b11) || misalign;
  assign accept      = (state_q == IDLE) && i_req_valid;
  assign timeout_hit = (cnt_q == 8'(TIMEOUT_CYCLES - 1));

  // Right-aligned memory data, sign- or zero-extended by access size.
  always_comb begin
    load_ext = i_data;
    case (size_q)
      2'b00:   load_ext = {{24{~uns_q & i_data[7]}}, i_data[7:0]};
      2'b01:   load_ext = {{16{~uns_q & i_data[15]}}, i_data[15:0]};
      default: load_ext = i_data;
    endcase
  end

  // State register; reset aborts any access in flight without a response.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and output decode; bus outputs are nonzero only in ISSUE.
  always_comb begin
    state_d     = state_q;
    o_req_ready = 1'b0;
    o_en        = 1'b0;
    o_we        = 1'b0;
    o_mask_type = 2'b00;
    o_addr      = 32'h0;
    o_data      = 32'h0;
    o_rsp_valid = 1'b0;
    o_rsp_err   = 1'b0;
    o_rsp_rdata = 32'h0;
    case (state_q)
      IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) state_d = reject ? RESP : ISSUE;
      end
      ISSUE: begin
        o_en        = 1'b1;
        o_we        = we_q;
        o_mask_type = size_q;
        o_addr      = addr_q;
        o_data      = wdata_q;
        state_d     = WAIT;
      end
      WAIT: begin
        if (i_ack || timeout_hit) state_d = RESP;
      end
      RESP: begin
        o_rsp_valid = 1'b1;
        o_rsp_err   = err_q;
        o_rsp_rdata = rdata_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request capture, wait counter and response data; ack is only looked at in WAIT.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
      cnt_q   <= 8'h0;
    end else begin
      if (accept) begin
        we_q    <= i_req_we;
        size_q  <= i_req_size;
        uns_q   <= i_req_unsigned;
        addr_q  <= i_req_addr;
        wdata_q <= i_req_wdata;
        cnt_q   <= 8'h0;
        rdata_q <= 32'h0;
        err_q   <= reject;
      end else if (state_q == WAIT) begin
        if (i_ack) begin
          rdata_q <= we_q ? 32'h0 : load_ext;
          err_q   <= i_err;
        end else if (timeout_hit) begin
          rdata_q <= 32'h0;
          err_q   <= 1'b1;
        end else begin
          cnt_q <= cnt_q + 8'h1;
        end
      end
    end
  end

endmodule
